// File: rtl/ppu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ppu_pkg
//  Brief    : Shared PPU constants and the palette address mirror helper.
//  Revision : 1.0 - initial release
// ============================================================================
package ppu_pkg;

  localparam int SCREEN_WIDTH    = 256;
  localparam int SCREEN_HEIGHT   = 240;

  // PPUMASK bit positions
  localparam int PPUMASK_GREY    = 0;
  localparam int PPUMASK_EMPH_LO = 5;

  // Greyscale keeps only the luma column of the colour code
  localparam logic [5:0] c_GREY_MASK = 6'h30;

  // Entries $10/$14/$18/$1C alias the background entries $00/$04/$08/$0C
  function automatic logic [4:0] pal_mirror(input logic [4:0] addr);
    return (addr[4] && (addr[1:0] == 2'b00)) ? (addr & 5'h0F) : addr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/palette_lut_if.sv
`default_nettype none
// ============================================================================
//  Module   : palette_lut_if
//  Brief    : CPU access bus to the palette RAM ($3F00-$3F1F window).
//  Revision : 1.0 - initial release
// ============================================================================
interface palette_lut_if;

  logic [4:0] cpu_addr;
  logic       cpu_wr;
  logic       cpu_rd;
  logic [7:0] cpu_din;
  logic [7:0] cpu_dout;

  // CPU / register-interface side
  modport master (
    output cpu_addr,
    output cpu_wr,
    output cpu_rd,
    output cpu_din,
    input  cpu_dout
  );

  // Palette block side
  modport slave (
    input  cpu_addr,
    input  cpu_wr,
    input  cpu_rd,
    input  cpu_din,
    output cpu_dout
  );

endinterface
`default_nettype wire

// File: rtl/palette_ram.sv
`default_nettype none
// ============================================================================
//  Module   : palette_ram
//  Brief    : 32x6 flop palette store, one write port, two combinational
//             read ports; address mirroring is applied on every port.
//  Revision : 1.0 - initial release
// ============================================================================
module palette_ram
  import ppu_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       wr_en,
  input  wire logic [4:0] wr_addr,
  input  wire logic [5:0] wr_data,
  input  wire logic [4:0] rd_ren_addr,
  output      logic [5:0] rd_ren_data,
  input  wire logic [4:0] rd_cpu_addr,
  output      logic [5:0] rd_cpu_data
);

  logic [5:0] r_mem [32];
  logic [4:0] w_wr_phys;

  assign w_wr_phys = pal_mirror(wr_addr);

  // Storage: asynchronous clear, single write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '{default: '0};
    end else if (wr_en) begin
      r_mem[w_wr_phys] <= wr_data;
    end
  end

  assign rd_ren_data = r_mem[pal_mirror(rd_ren_addr)];
  assign rd_cpu_data = r_mem[pal_mirror(rd_cpu_addr)];

endmodule
`default_nettype wire

// File: rtl/palette_lut.sv
`default_nettype none
// ============================================================================
//  Module   : palette_lut
//  Brief    : Palette index to NES colour conversion with greyscale/emphasis,
//             CPU palette access and an x/y pixel counter with frame markers.
//  Revision : 1.0 - initial release
// ============================================================================
module palette_lut #(
  parameter int SCREEN_WIDTH  = ppu_pkg::SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = ppu_pkg::SCREEN_HEIGHT
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       px_en,
  input  wire logic [4:0] palette_idx,
  input  wire logic [7:0] ppumask,
  input  wire logic       vblank,
  palette_lut_if.slave    cpu,
  output      logic       pix_valid,
  output      logic [5:0] pix_color,
  output      logic [2:0] pix_emph,
  output      logic [7:0] pix_x,
  output      logic [7:0] pix_y,
  output      logic       pix_sof,
  output      logic       pix_eol
);

  import ppu_pkg::PPUMASK_GREY;
  import ppu_pkg::PPUMASK_EMPH_LO;
  import ppu_pkg::c_GREY_MASK;
  import ppu_pkg::pal_mirror;

  localparam logic [7:0] c_X_LAST = 8'(SCREEN_WIDTH - 1);
  localparam logic [7:0] c_Y_LAST = 8'(SCREEN_HEIGHT - 1);

  // Stage-1 registers
  logic       r_s1_valid;
  logic [4:0] r_s1_idx;
  logic       r_s1_grey;
  logic [2:0] r_s1_emph;

  // Pixel counter and vblank edge detector
  logic [7:0] r_cnt_x;
  logic [7:0] r_cnt_y;
  logic       r_vblank_d;
  logic       w_vblank_rise;

  logic [4:0] w_ren_idx;
  logic [5:0] w_ren_data;
  logic [5:0] w_cpu_data;
  logic [5:0] w_ren_color;
  logic [5:0] w_cpu_color;
  logic [7:0] r_cpu_dout;

  // Bits of the input buses this block has no use for
  logic w_unused_bits;
  assign w_unused_bits = ^{ppumask[4:1], cpu.cpu_din[7:6]};

  palette_ram u_palette_ram (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (cpu.cpu_wr),
    .wr_addr     (cpu.cpu_addr),
    .wr_data     (cpu.cpu_din[5:0]),
    .rd_ren_addr (r_s1_idx),
    .rd_ren_data (w_ren_data),
    .rd_cpu_addr (cpu.cpu_addr),
    .rd_cpu_data (w_cpu_data)
  );

  // Pixel 0 of every palette is the shared backdrop, sprite or background
  assign w_ren_idx = (palette_idx[1:0] == 2'b00) ? 5'd0 : pal_mirror(palette_idx);

  assign w_ren_color = r_s1_grey ? (w_ren_data & c_GREY_MASK) : w_ren_data;
  assign w_cpu_color = ppumask[PPUMASK_GREY] ? (w_cpu_data & c_GREY_MASK) : w_cpu_data;

  assign w_vblank_rise = vblank & ~r_vblank_d;

  // Stage 1: capture the mapped index and the mask bits that travel with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_idx   <= '0;
      r_s1_grey  <= 1'b0;
      r_s1_emph  <= '0;
    end else begin
      r_s1_valid <= px_en;
      r_s1_idx   <= w_ren_idx;
      r_s1_grey  <= ppumask[PPUMASK_GREY];
      r_s1_emph  <= ppumask[PPUMASK_EMPH_LO +: 3];
    end
  end

  // Stage 2: RAM lookup result plus the coordinates owned by this pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid <= 1'b0;
      pix_color <= '0;
      pix_emph  <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_sof   <= 1'b0;
      pix_eol   <= 1'b0;
    end else begin
      pix_valid <= r_s1_valid;
      pix_color <= w_ren_color;
      pix_emph  <= r_s1_emph;
      pix_x     <= r_cnt_x;
      pix_y     <= r_cnt_y;
      pix_sof   <= r_s1_valid && (r_cnt_x == 8'd0) && (r_cnt_y == 8'd0);
      pix_eol   <= r_s1_valid && (r_cnt_x == c_X_LAST);
    end
  end

  // Pixel counter: steps with each emitted pixel, vblank rise resyncs to 0,0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_x <= '0;
      r_cnt_y <= '0;
    end else if (w_vblank_rise) begin
      r_cnt_x <= '0;
      r_cnt_y <= '0;
    end else if (r_s1_valid) begin
      if (r_cnt_x == c_X_LAST) begin
        r_cnt_x <= '0;
        r_cnt_y <= (r_cnt_y == c_Y_LAST) ? 8'd0 : r_cnt_y + 8'd1;
      end else begin
        r_cnt_x <= r_cnt_x + 8'd1;
      end
    end
  end

  // Vblank history for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vblank_d <= 1'b0;
    end else begin
      r_vblank_d <= vblank;
    end
  end

  // CPU read data: loads on a read strobe only, otherwise holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_dout <= '0;
    end else if (cpu.cpu_rd) begin
      r_cpu_dout <= {2'b00, w_cpu_color};
    end
  end

  assign cpu.cpu_dout = r_cpu_dout;

endmodule
`default_nettype wire

// File: tb/tb_palette_lut.sv
`default_nettype none
// ============================================================================
//  Module   : tb_palette_lut
//  Brief    : Directed self-checking bench for palette_lut.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_palette_lut;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       px_en;
  logic [4:0] palette_idx;
  logic [7:0] ppumask;
  logic       vblank;
  logic       pix_valid;
  logic [5:0] pix_color;
  logic [2:0] pix_emph;
  logic [7:0] pix_x;
  logic [7:0] pix_y;
  logic       pix_sof;
  logic       pix_eol;

  int n_checks = 0;
  int n_errors = 0;

  palette_lut_if cpu_bus ();

  palette_lut dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .px_en       (px_en),
    .palette_idx (palette_idx),
    .ppumask     (ppumask),
    .vblank      (vblank),
    .cpu         (cpu_bus),
    .pix_valid   (pix_valid),
    .pix_color   (pix_color),
    .pix_emph    (pix_emph),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_sof     (pix_sof),
    .pix_eol     (pix_eol)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cpu_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_bus.cpu_addr = a;
    cpu_bus.cpu_din  = d;
    cpu_bus.cpu_wr   = 1'b1;
    @(negedge clk);
    cpu_bus.cpu_wr   = 1'b0;
  endtask

  task automatic cpu_read(input logic [4:0] a, output logic [7:0] d);
    @(negedge clk);
    cpu_bus.cpu_addr = a;
    cpu_bus.cpu_rd   = 1'b1;
    @(negedge clk);
    cpu_bus.cpu_rd   = 1'b0;
    d = cpu_bus.cpu_dout;
  endtask

  // One pixel in; checks it is absent after 1 cycle and present after 2
  task automatic send_px(input logic [4:0] idx, input string tag, input logic [5:0] exp_color);
    @(negedge clk);
    px_en       = 1'b1;
    palette_idx = idx;
    @(negedge clk);
    px_en       = 1'b0;
    check({tag, "_lat1"}, 32'(pix_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(pix_valid), 32'd1);
    check({tag, "_color"}, 32'(pix_color), 32'(exp_color));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    int k, c, ex, ey, nbad;

    rst_n = 1'b0; px_en = 1'b0; palette_idx = '0; ppumask = '0; vblank = 1'b0;
    cpu_bus.cpu_addr = '0; cpu_bus.cpu_wr = 1'b0; cpu_bus.cpu_rd = 1'b0; cpu_bus.cpu_din = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", 32'(pix_valid), 32'd0);
    check("rst_color", 32'(pix_color), 32'd0);
    check("rst_xy", {16'd0, pix_x, pix_y}, 32'd0);
    check("rst_marks", {pix_sof, pix_eol, pix_emph}, 32'd0);
    check("rst_dout", 32'(cpu_bus.cpu_dout), 32'd0);

    // Mirroring
    cpu_write(5'h10, 8'h2A);
    cpu_read(5'h00, rd);  check("mir_10_00", 32'(rd), 32'h2A);
    cpu_write(5'h04, 8'h11);
    cpu_read(5'h14, rd);  check("mir_04_14", 32'(rd), 32'h11);
    cpu_write(5'h05, 8'h16);
    cpu_read(5'h15, rd);  check("mir_15_none", 32'(rd), 32'h00);
    cpu_read(5'h05, rd);  check("mir_05", 32'(rd), 32'h16);
    cpu_write(5'h1C, 8'hFF);
    cpu_read(5'h0C, rd);  check("mir_1c_top_bits", 32'(rd), 32'h3F);

    // Backdrop forcing
    cpu_write(5'h00, 8'h0F);
    cpu_write(5'h15, 8'h16);
    send_px(5'h14, "bd_14", 6'h0F);
    send_px(5'h15, "bd_15", 6'h16);
    @(negedge clk);
    check("bd_valid_drop", 32'(pix_valid), 32'd0);

    // Greyscale and emphasis
    cpu_write(5'h01, 8'h27);
    ppumask = 8'h01;
    send_px(5'h01, "grey", 6'h20);
    cpu_read(5'h01, rd);  check("grey_cpu", 32'(rd), 32'h20);
    ppumask = 8'hE0;
    send_px(5'h01, "emph", 6'h27);
    check("emph_bits", 32'(pix_emph), 32'h7);
    ppumask = 8'h00;

    // Simultaneous read and write of the same entry
    cpu_write(5'h02, 8'h0A);
    @(negedge clk);
    cpu_bus.cpu_addr = 5'h02; cpu_bus.cpu_din = 8'h1B;
    cpu_bus.cpu_wr = 1'b1; cpu_bus.cpu_rd = 1'b1;
    @(negedge clk);
    cpu_bus.cpu_wr = 1'b0; cpu_bus.cpu_rd = 1'b0;
    check("rdwr_old", 32'(cpu_bus.cpu_dout), 32'h0A);
    cpu_read(5'h02, rd);  check("rdwr_new", 32'(rd), 32'h1B);

    // Write/lookup collision with back-to-back pixels
    cpu_write(5'h03, 8'h05);
    @(negedge clk);
    px_en = 1'b1; palette_idx = 5'h03;
    @(negedge clk);
    cpu_bus.cpu_addr = 5'h03; cpu_bus.cpu_din = 8'h30; cpu_bus.cpu_wr = 1'b1;
    @(negedge clk);
    px_en = 1'b0; cpu_bus.cpu_wr = 1'b0;
    check("coll_v1", 32'(pix_valid), 32'd1);
    check("coll_old", 32'(pix_color), 32'h05);
    @(negedge clk);
    check("coll_v2", 32'(pix_valid), 32'd1);
    check("coll_new", 32'(pix_color), 32'h30);

    // Full-frame counter run from a clean reset
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    k = 0; c = 0; ex = 0; ey = 0; nbad = 0;
    palette_idx = 5'h01;
    while (k < 61441 && c < 61441 + 20) begin
      @(negedge clk);
      px_en = (c < 61441);
      c++;
      if (pix_valid) begin
        if (k == 0) begin
          check("cnt_first_sof", 32'(pix_sof), 32'd1);
          check("cnt_first_xy", {16'd0, pix_x, pix_y}, 32'h0000);
        end
        if (k == 255) begin
          check("cnt_eol", 32'(pix_eol), 32'd1);
          check("cnt_eol_x", 32'(pix_x), 32'd255);
        end
        if (k == 256) check("cnt_wrap_xy", {16'd0, pix_x, pix_y}, 32'h0001);
        if (k == 61439) begin
          check("cnt_last_xy", {16'd0, pix_x, pix_y}, 32'hFFEF);
          check("cnt_last_eol", 32'(pix_eol), 32'd1);
        end
        if (k == 61440) begin
          check("cnt_frame_wrap_xy", {16'd0, pix_x, pix_y}, 32'h0000);
          check("cnt_frame_wrap_sof", 32'(pix_sof), 32'd1);
        end
        if (int'(pix_x) != ex || int'(pix_y) != ey ||
            pix_sof != (ex == 0 && ey == 0) || pix_eol != (ex == 255))
          nbad++;
        if (ex == 255) begin
          ex = 0;
          ey = (ey == 239) ? 0 : ey + 1;
        end else begin
          ex = ex + 1;
        end
        k++;
      end
    end
    px_en = 1'b0;
    check("cnt_pixels", 32'(k), 32'd61441);
    check("cnt_model_bad", 32'(nbad), 32'd0);

    // Vblank resync from a partial line (counter sits at x=1 here)
    send_px(5'h01, "vb_pre0", 6'h00);
    send_px(5'h01, "vb_pre1", 6'h00);
    send_px(5'h01, "vb_pre2", 6'h00);
    check("vb_pre_x", 32'(pix_x), 32'd3);
    @(negedge clk); vblank = 1'b1;
    repeat (3) @(negedge clk);
    vblank = 1'b0;
    send_px(5'h01, "vb_post", 6'h00);
    check("vb_post_xy", {16'd0, pix_x, pix_y}, 32'h0000);
    check("vb_post_sof", 32'(pix_sof), 32'd1);

    // Reset asserted with pixels in flight
    cpu_write(5'h01, 8'h27);
    cpu_read(5'h01, rd);  check("mrst_pre_dout", 32'(rd), 32'h27);
    @(negedge clk);
    px_en = 1'b1; palette_idx = 5'h01;
    repeat (3) @(negedge clk);
    check("mrst_pre_valid", 32'(pix_valid), 32'd1);
    check("mrst_pre_color", 32'(pix_color), 32'h27);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_valid", 32'(pix_valid), 32'd0);
    check("mrst_color", 32'(pix_color), 32'd0);
    check("mrst_xy", {16'd0, pix_x, pix_y}, 32'd0);
    check("mrst_marks", {pix_sof, pix_eol, pix_emph}, 32'd0);
    check("mrst_dout", 32'(cpu_bus.cpu_dout), 32'd0);
    @(negedge clk);
    px_en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_dropped", 32'(pix_valid), 32'd0);
    cpu_read(5'h01, rd);  check("mrst_ram_clear", 32'(rd), 32'h00);
    send_px(5'h01, "mrst_post", 6'h00);
    check("mrst_post_xy", {16'd0, pix_x, pix_y}, 32'h0000);
    check("mrst_post_sof", 32'(pix_sof), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
